// File: rtl/clct_pid_monitor.sv
// Per-code occupancy monitor for the 5-bit CLCT pattern ID: 32 saturating live
// counters with a lossless snapshot sweep into a VME-readable shadow bank.

module clct_pid_cell #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             cpy,
    output logic [CNT_W-1:0] shadow
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cpy) begin
            // An event landing on the swept code opens the next interval at 1
            shadow <= cnt;
            cnt    <= inc ? CNT_W'(1) : '0;
        end else if (inc && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module clct_pid_monitor #(
    parameter int CNT_W = 16,
    parameter int TOT_W = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pid_valid,
    input  logic [4:0]       pid_in,
    input  logic             cnt_clear,
    input  logic             snap_req,
    input  logic [4:0]       rd_adr,
    output logic [CNT_W-1:0] rd_data,
    output logic [TOT_W-1:0] tot_cnt,
    output logic             snap_busy,
    output logic             snap_done,
    output logic             snap_valid,
    output logic             err_lct1_only
);
    localparam int NUM_CODES = 32;

    typedef enum logic {IDLE, COPY} state_t;

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       done_d, valid_d;
    logic       ev_ok, copy_en;

    logic [NUM_CODES-1:0][CNT_W-1:0] shadow;

    assign ev_ok     = pid_valid && !cnt_clear;
    assign copy_en   = (state_q == COPY) && !cnt_clear;
    assign snap_busy = (state_q == COPY);

    for (genvar i = 0; i < NUM_CODES; i++) begin : g_cell
        clct_pid_cell #(.CNT_W(CNT_W)) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (cnt_clear),
            .inc     (ev_ok && pid_in == 5'(i)),
            .cpy     (copy_en && idx_q == 5'(i)),
            .shadow  (shadow[i])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        valid_d = snap_valid;
        if (cnt_clear) begin
            // Abort leaves a partial bank behind; snap_valid is already low in COPY
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (snap_req) begin
                    state_d = COPY;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
                COPY: begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_done  <= 1'b0;
            snap_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_done  <= done_d;
            snap_valid <= valid_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tot_cnt       <= '0;
            err_lct1_only <= 1'b0;
        end else if (cnt_clear) begin
            tot_cnt       <= '0;
            err_lct1_only <= 1'b0;
        end else if (pid_valid) begin
            if (tot_cnt != {TOT_W{1'b1}})
                tot_cnt <= tot_cnt + TOT_W'(1);
            if (pid_in == 5'd30)
                err_lct1_only <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= shadow[rd_adr];
    end
endmodule

// File: tb/tb_clct_pid_monitor.sv
// Directed bench for clct_pid_monitor; narrow counters keep saturation runs short.

module tb_clct_pid_monitor;
    localparam int CNT_W = 8;
    localparam int TOT_W = 10;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             pid_valid;
    logic [4:0]       pid_in;
    logic             cnt_clear;
    logic             snap_req;
    logic [4:0]       rd_adr;
    logic [CNT_W-1:0] rd_data;
    logic [TOT_W-1:0] tot_cnt;
    logic             snap_busy, snap_done, snap_valid, err_lct1_only;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_q[$];

    clct_pid_monitor #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pid_valid     (pid_valid),
        .pid_in        (pid_in),
        .cnt_clear     (cnt_clear),
        .snap_req      (snap_req),
        .rd_adr        (rd_adr),
        .rd_data       (rd_data),
        .tot_cnt       (tot_cnt),
        .snap_busy     (snap_busy),
        .snap_done     (snap_done),
        .snap_valid    (snap_valid),
        .err_lct1_only (err_lct1_only)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic events(input logic [4:0] code, input int n);
        pid_valid = 1'b1;
        pid_in    = code;
        repeat (n) tick();
        pid_valid = 1'b0;
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    // Waits a bounded number of cycles for snap_done; returns cycles taken.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (snap_done) break;
        end
        chk(tag, 32'(snap_done), 32'd1);
    endtask

    task automatic read_chk(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        rd_adr = a;
        tick();
        chk($sformatf("shadow[%0d]", a), 32'(rd_data), exp_q.pop_front());
    endtask

    initial begin
        int n;
        reset_n = 1'b0; pid_valid = 1'b0; pid_in = '0;
        cnt_clear = 1'b0; snap_req = 1'b0; rd_adr = '0;
        #12;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_tot", 32'(tot_cnt), 0);
        chk("rst_busy", 32'(snap_busy), 0);
        chk("rst_done", 32'(snap_done), 0);
        chk("rst_valid", 32'(snap_valid), 0);
        chk("rst_err", 32'(err_lct1_only), 0);
        reset_n = 1'b1;
        tick();

        // Basic count and full sweep latency
        events(5'd3, 5);
        chk("tot_5", 32'(tot_cnt), 5);
        pulse_snap();
        chk("busy_start", 32'(snap_busy), 1);
        chk("valid_low", 32'(snap_valid), 0);
        wait_done("done_basic", n);
        chk("done_latency", 32'(n), 32);
        chk("valid_set", 32'(snap_valid), 1);
        chk("busy_end", 32'(snap_busy), 0);
        tick();
        chk("done_pulse", 32'(snap_done), 0);
        for (int a = 0; a < 32; a++) read_chk(5'(a), (a == 3) ? 32'd5 : 32'd0);
        chk("tot_kept", 32'(tot_cnt), 5);
        pulse_snap();
        wait_done("done_empty", n);
        read_chk(5'd3, 0);

        // Saturation of a code counter and the total
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        chk("tot_clr", 32'(tot_cnt), 0);
        events(5'd7, 1023);
        chk("tot_max", 32'(tot_cnt), 1023);
        events(5'd7, 1);
        chk("tot_sat", 32'(tot_cnt), 1023);
        pulse_snap();
        wait_done("done_sat", n);
        read_chk(5'd7, 255);
        read_chk(5'd6, 0);

        // Events racing the sweep: 2 already swept, 20 ahead, 10 on the copy edge
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        events(5'd10, 4);
        pulse_snap();
        repeat (4) tick();
        events(5'd2, 1);
        events(5'd20, 1);
        repeat (4) tick();
        events(5'd10, 1);
        wait_done("done_race", n);
        pulse_snap();  // issued in the snap_done cycle
        chk("b2b_busy", 32'(snap_busy), 1);
        wait_done("done_b2b", n);
        read_chk(5'd10, 1);
        read_chk(5'd2, 1);
        read_chk(5'd20, 0);
        chk("tot_race", 32'(tot_cnt), 7);
        pulse_snap();  // recheck of the first sweep is impossible now; verify quiet bank
        wait_done("done_quiet", n);
        read_chk(5'd10, 0);

        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        events(5'd10, 4);
        pulse_snap();
        repeat (4) tick();
        events(5'd2, 1);
        events(5'd20, 1);
        repeat (4) tick();
        events(5'd10, 1);
        wait_done("done_race2", n);
        read_chk(5'd10, 4);
        read_chk(5'd20, 1);
        read_chk(5'd2, 0);

        // Clear aborts a sweep at idx 15; bank currently holds [10]=4,[20]=1
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        for (int a = 0; a < 32; a++) events(5'(a), 2);
        chk("err_set", 32'(err_lct1_only), 1);
        pulse_snap();
        repeat (15) tick();
        chk("busy_mid", 32'(snap_busy), 1);
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        chk("abort_busy", 32'(snap_busy), 0);
        chk("abort_done", 32'(snap_done), 0);
        chk("abort_valid", 32'(snap_valid), 0);
        chk("abort_tot", 32'(tot_cnt), 0);
        chk("abort_err", 32'(err_lct1_only), 0);
        tick();
        chk("abort_no_done", 32'(snap_done), 0);
        for (int a = 0; a < 32; a++)
            read_chk(5'(a), (a < 15) ? 32'd2 : (a == 20) ? 32'd1 : 32'd0);

        // Sticky error flag, then reset in the middle of a sweep
        events(5'd30, 1);
        chk("err_30", 32'(err_lct1_only), 1);
        pulse_snap();
        wait_done("done_err", n);
        events(5'd5, 3);
        chk("err_sticky", 32'(err_lct1_only), 1);
        read_chk(5'd30, 1);
        pulse_snap();
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(rd_data), 0);
        chk("mid_rst_tot", 32'(tot_cnt), 0);
        chk("mid_rst_busy", 32'(snap_busy), 0);
        chk("mid_rst_valid", 32'(snap_valid), 0);
        chk("mid_rst_err", 32'(err_lct1_only), 0);
        tick();
        reset_n = 1'b1;
        read_chk(5'd30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
